card_hand_bank: RTL and testbench

Parametrised card-hand storage and scoring bank for the baccarat datapath. It generalises the fixed six card registers and two combinational score blocks into NUM_HANDS hands of up to MAX_CARDS cards each. It adds an internal 1..13 card source, a valid/ready deal handshake, per-hand card counters and full flags, and a registered modulo-10 running score per hand. It sits between the dealing FSM, which issues deal requests, and the card7seg and score-compare logic, which consume the packed outputs.

---
 rtl/card_hand_bank.sv | 170 +++++++++++++++++
 tb/tb_card_hand_bank.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_hand_bank.sv
// card_hand_bank: NUM_HANDS x MAX_CARDS card storage with an internal 1..13
// card source, a valid/ready deal port and a registered baccarat score
// (modulo 10) per hand.
//
// Deal handshake: a card is accepted on a rising slow_clock edge where
// deal_valid && deal_ready. deal_ready is purely combinational and does not
// depend on deal_valid; a requester may hold deal_valid high across cycles
// and it will be accepted on the first edge where deal_ready is also high.
module card_hand_bank #(
  parameter int NUM_HANDS = 2,
  parameter int MAX_CARDS = 3,
  localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
  localparam int CW = $clog2(MAX_CARDS + 1)
) (
  input  logic                             slow_clock,
  input  logic                             resetb,
  input  logic                             clear,
  input  logic                             deal_valid,
  input  logic [HW-1:0]                    deal_hand,
  output logic                             deal_ready,
  output logic                             deal_done,
  output logic [3:0]                       last_card,
  output logic [NUM_HANDS*MAX_CARDS*4-1:0] card_code,
  output logic [NUM_HANDS*CW-1:0]          card_count,
  output logic [NUM_HANDS*4-1:0]           score,
  output logic [NUM_HANDS-1:0]             hand_full,
  output logic                             state_dbg
);

  localparam logic IDLE  = 1'b0;
  localparam logic SCORE = 1'b1;

  logic          state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    code_q [NUM_HANDS*MAX_CARDS];
  logic [3:0]    code_d [NUM_HANDS*MAX_CARDS];
  logic [CW-1:0] count_q [NUM_HANDS];
  logic [CW-1:0] count_d [NUM_HANDS];
  logic [3:0]    score_q [NUM_HANDS];
  logic [3:0]    score_d [NUM_HANDS];
  logic [3:0]    last_q, last_d;
  logic [HW-1:0] idx_q, idx_d;
  logic [3:0]    card_q, card_d;
  logic          done_q, done_d;

  logic          hand_ok;
  logic          sel_full;
  logic          accept;

  // Adds one card's baccarat value (10, J, Q, K count as 0) to a score.
  function automatic logic [3:0] add_mod10(input logic [3:0] acc,
                                           input logic [3:0] card);
    logic [3:0] v;
    logic [4:0] s;
    v = (card >= 4'd10) ? 4'd0 : card;
    s = {1'b0, acc} + {1'b0, v};
    if (s >= 5'd10) begin
      s = s - 5'd10;
    end
    return s[3:0];
  endfunction

  // Free-running card source 1..13; never paused by clear or busy states.
  always_comb begin
    cnt_d = (cnt_q == 4'd13) ? 4'd1 : cnt_q + 4'd1;
  end

  // Decode the requested hand: range check and its full flag.
  always_comb begin
    hand_ok  = 1'b0;
    sel_full = 1'b0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      if (deal_hand == HW'(h)) begin
        hand_ok  = 1'b1;
        sel_full = (count_q[h] == CW'(MAX_CARDS));
      end
    end
  end

  assign deal_ready = (state_q == IDLE) && !clear && hand_ok && !sel_full;
  assign accept     = deal_valid && deal_ready;

  // Next-state logic: card write on accept, score update one cycle later.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    count_d = count_q;
    score_d = score_q;
    last_d  = last_q;
    idx_d   = idx_q;
    card_d  = card_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      for (int i = 0; i < NUM_HANDS*MAX_CARDS; i++) code_d[i] = 4'd0;
      for (int h = 0; h < NUM_HANDS; h++) begin
        count_d[h] = '0;
        score_d[h] = 4'd0;
      end
      last_d = 4'd0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        for (int h = 0; h < NUM_HANDS; h++) begin
          if (deal_hand == HW'(h)) begin
            for (int s = 0; s < MAX_CARDS; s++) begin
              if (count_q[h] == CW'(s)) code_d[h*MAX_CARDS+s] = cnt_q;
            end
            count_d[h] = count_q[h] + CW'(1);
          end
        end
        last_d  = cnt_q;
        idx_d   = deal_hand;
        card_d  = cnt_q;
        state_d = SCORE;
      end
    end else begin
      for (int h = 0; h < NUM_HANDS; h++) begin
        if (idx_q == HW'(h)) score_d[h] = add_mod10(score_q[h], card_q);
      end
      done_d  = 1'b1;
      state_d = IDLE;
    end
  end

  // State registers; reset drops any pending score and restarts the source.
  always_ff @(posedge slow_clock or posedge resetb) begin
    if (resetb) begin
      state_q <= IDLE;
      cnt_q   <= 4'd1;
      code_q  <= '{default: '0};
      count_q <= '{default: '0};
      score_q <= '{default: '0};
      last_q  <= 4'd0;
      idx_q   <= '0;
      card_q  <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      count_q <= count_d;
      score_q <= score_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      card_q  <= card_d;
      done_q  <= done_d;
    end
  end

  // Pack per-hand storage onto the flat output buses.
  always_comb begin
    card_code  = '0;
    card_count = '0;
    score      = '0;
    hand_full  = '0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      for (int s = 0; s < MAX_CARDS; s++) begin
        card_code[(h*MAX_CARDS+s)*4 +: 4] = code_q[h*MAX_CARDS+s];
      end
      card_count[h*CW +: CW] = count_q[h];
      score[h*4 +: 4]        = score_q[h];
      hand_full[h]           = (count_q[h] == CW'(MAX_CARDS));
    end
  end

  assign deal_done = done_q;
  assign last_card = last_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_card_hand_bank.sv
// Directed bench for card_hand_bank (2 hands x 3 cards, plus a 3-hand build
// for the out-of-range hand index).
module tb_card_hand_bank;

  logic        slow_clock = 1'b0;
  logic        resetb;
  logic        clear;
  logic        deal_valid;
  logic [0:0]  deal_hand;
  logic        deal_ready;
  logic        deal_done;
  logic [3:0]  last_card;
  logic [23:0] card_code;
  logic [3:0]  card_count;
  logic [7:0]  score;
  logic [1:0]  hand_full;
  logic        state_dbg;

  logic        deal_valid3;
  logic [1:0]  deal_hand3;
  logic        deal_ready3;
  logic        deal_done3;
  logic [3:0]  last_card3;
  logic [35:0] card_code3;
  logic [5:0]  card_count3;
  logic [11:0] score3;
  logic [2:0]  hand_full3;
  logic        state_dbg3;

  int checks = 0;
  int errors = 0;
  int done_cnt;
  logic [3:0] cnt_m;

  // Clock / reset block
  always #5 slow_clock = ~slow_clock;

  // Tracks which card the next edge would capture, used only to time deals.
  always @(posedge slow_clock or posedge resetb) begin
    if (resetb) cnt_m <= 4'd1;
    else        cnt_m <= (cnt_m == 4'd13) ? 4'd1 : cnt_m + 4'd1;
  end

  card_hand_bank dut (
    .slow_clock(slow_clock), .resetb(resetb), .clear(clear),
    .deal_valid(deal_valid), .deal_hand(deal_hand), .deal_ready(deal_ready),
    .deal_done(deal_done), .last_card(last_card), .card_code(card_code),
    .card_count(card_count), .score(score), .hand_full(hand_full),
    .state_dbg(state_dbg)
  );

  card_hand_bank #(.NUM_HANDS(3)) dut3 (
    .slow_clock(slow_clock), .resetb(resetb), .clear(clear),
    .deal_valid(deal_valid3), .deal_hand(deal_hand3), .deal_ready(deal_ready3),
    .deal_done(deal_done3), .last_card(last_card3), .card_code(card_code3),
    .card_count(card_count3), .score(score3), .hand_full(hand_full3),
    .state_dbg(state_dbg3)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] slot(input int h, input int s);
    return card_code[(h*3+s)*4 +: 4];
  endfunction

  function automatic logic [1:0] cnt_of(input int h);
    return card_count[h*2 +: 2];
  endfunction

  function automatic logic [3:0] score_of(input int h);
    return score[h*4 +: 4];
  endfunction

  // Driver: wait until the next edge captures card v (bounded).
  task automatic wait_card(input logic [3:0] v);
    int n = 0;
    while (cnt_m != v && n < 30) begin
      step();
      n++;
    end
    chk("align", cnt_m, v);
  endtask

  // Driver: deal one card to a hand and run through its score cycle.
  task automatic deal(input int h, input logic [3:0] card);
    wait_card(card);
    deal_valid = 1'b1;
    deal_hand  = h[0:0];
    step();
    deal_valid = 1'b0;
    chk("deal_last_card", last_card, card);
    step();
    chk("deal_done_pulse", deal_done, 1'b1);
  endtask

  initial begin
    resetb = 1'b1; clear = 1'b0; deal_valid = 1'b0; deal_hand = 1'b0;
    deal_valid3 = 1'b0; deal_hand3 = 2'd0;
    #12;
    // Reset state
    chk("rst_card_code", card_code, 24'h0);
    chk("rst_count", card_count, 4'h0);
    chk("rst_score", score, 8'h0);
    chk("rst_full", hand_full, 2'b00);
    chk("rst_last", last_card, 4'h0);
    chk("rst_done", deal_done, 1'b0);
    chk("rst_ready", deal_ready, 1'b1);

    // First edge after reset deals card 1 to hand 0
    resetb = 1'b0; deal_valid = 1'b1; deal_hand = 1'b0;
    step();
    deal_valid = 1'b0;
    chk("first_slot00", slot(0, 0), 4'd1);
    chk("first_count0", cnt_of(0), 2'd1);
    chk("first_ready_busy", deal_ready, 1'b0);
    chk("first_done_early", deal_done, 1'b0);
    step();
    chk("first_score0", score_of(0), 4'd1);
    chk("first_done", deal_done, 1'b1);
    step();
    chk("first_done_clears", deal_done, 1'b0);

    // 7 then 8 to hand 1 -> 15 mod 10 = 5
    deal(1, 4'd7);
    chk("h1_score_7", score_of(1), 4'd7);
    deal(1, 4'd8);
    chk("h1_score_7_8", score_of(1), 4'd5);

    // Fill hand 0: 1 + 9 + 13(=0) -> 0
    deal(0, 4'd9);
    deal(0, 4'd13);
    chk("h0_score_full", score_of(0), 4'd0);
    chk("h0_full_flags", hand_full, 2'b01);
    deal_hand = 1'b0;
    #1 chk("h0_full_ready", deal_ready, 1'b0);
    deal_hand = 1'b1;
    #1 chk("h1_ready", deal_ready, 1'b1);

    // Fourth request to full hand 0 is ignored
    deal_valid = 1'b1; deal_hand = 1'b0;
    step();
    step();
    deal_valid = 1'b0;
    chk("full_count0", cnt_of(0), 2'd3);
    chk("full_slot00", slot(0, 0), 4'd1);
    chk("full_slot01", slot(0, 1), 4'd9);
    chk("full_slot02", slot(0, 2), 4'd13);
    chk("full_last", last_card, 4'd13);
    chk("full_no_done", deal_done, 1'b0);

    // Following deal to hand 1: 12 counts as 0
    deal(1, 4'd12);
    chk("h1_slot12", slot(1, 2), 4'd12);
    chk("h1_score_12", score_of(1), 4'd5);
    chk("both_full", hand_full, 2'b11);

    // Plain clear
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_code", card_code, 24'h0);
    chk("clr_count", card_count, 4'h0);
    chk("clr_score", score, 8'h0);
    chk("clr_full", hand_full, 2'b00);
    chk("clr_last", last_card, 4'h0);

    // Hold deal_valid for 6 cycles: accepts on alternate edges (2,4,6)
    wait_card(4'd2);
    deal_valid = 1'b1; deal_hand = 1'b0; done_cnt = 0;
    repeat (6) begin
      step();
      done_cnt += int'(deal_done);
    end
    deal_valid = 1'b0;
    chk("hold_done_pulses", done_cnt, 3);
    chk("hold_count0", cnt_of(0), 2'd3);
    chk("hold_slots", {slot(0, 0), slot(0, 1), slot(0, 2)}, 12'h246);
    chk("hold_score0", score_of(0), 4'd2);

    // clear together with deal_valid: clear wins
    clear = 1'b1; deal_valid = 1'b1; deal_hand = 1'b1;
    step();
    clear = 1'b0; deal_valid = 1'b0;
    chk("clr_deal_count", card_count, 4'h0);
    chk("clr_deal_state", state_dbg, 1'b0);
    chk("clr_deal_code", card_code, 24'h0);

    // clear during SCORE: pending update discarded
    wait_card(4'd5);
    deal_valid = 1'b1; deal_hand = 1'b1;
    step();
    deal_valid = 1'b0;
    chk("cs_count1", cnt_of(1), 2'd1);
    chk("cs_state", state_dbg, 1'b1);
    clear = 1'b1;
    #1 chk("cs_ready_clear", deal_ready, 1'b0);
    step();
    chk("cs_code", card_code, 24'h0);
    chk("cs_count", card_count, 4'h0);
    chk("cs_score", score, 8'h0);
    chk("cs_last", last_card, 4'h0);
    chk("cs_no_done", deal_done, 1'b0);
    clear = 1'b0;
    #1 chk("cs_ready_back", deal_ready, 1'b1);
    step();
    chk("cs_no_done_late", deal_done, 1'b0);

    // Asynchronous reset mid-SCORE
    wait_card(4'd3);
    deal_valid = 1'b1; deal_hand = 1'b0;
    step();
    deal_valid = 1'b0;
    chk("ar_slot00", slot(0, 0), 4'd3);
    #2 resetb = 1'b1;
    #1;
    chk("ar_code", card_code, 24'h0);
    chk("ar_count", card_count, 4'h0);
    chk("ar_last", last_card, 4'h0);
    chk("ar_state", state_dbg, 1'b0);
    step();
    chk("ar_no_done", deal_done, 1'b0);
    chk("ar_score", score, 8'h0);
    resetb = 1'b0; deal_valid = 1'b1; deal_hand = 1'b0;
    step();
    deal_valid = 1'b0;
    chk("ar_restart_slot", slot(0, 0), 4'd1);
    step();
    chk("ar_restart_score", score_of(0), 4'd1);
    chk("ar_restart_done", deal_done, 1'b1);

    // Three-hand build: index 3 is out of range
    deal_hand3 = 2'd3; deal_valid3 = 1'b1;
    #1 chk("nh3_ready_oob", deal_ready3, 1'b0);
    step();
    step();
    chk("nh3_count_oob", card_count3, 6'h00);
    chk("nh3_code_oob", card_code3, 36'h0);
    chk("nh3_state_oob", state_dbg3, 1'b0);
    deal_hand3 = 2'd2;
    #1 chk("nh3_ready_h2", deal_ready3, 1'b1);
    step();
    deal_valid3 = 1'b0;
    chk("nh3_count_h2", card_count3, 6'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
